// File: rtl/layer_sequencer.sv
// Layer sequencer: buffers one input vector, broadcasts it to all neurons, captures and drains activations.
// Optional WAIT watchdog enabled by defining LAYER_WAIT_TIMEOUT_EN.
module layer_sequencer #(
    parameter int NUM_INPUTS     = 784,
    parameter int NUM_NEURONS    = 30,
    parameter int DATA_WIDTH     = 16,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [DATA_WIDTH-1:0]             in_data,
    input  logic                              in_valid,
    output logic                              in_ready,
    output logic [DATA_WIDTH-1:0]             neuron_in,
    output logic                              neuron_in_valid,
    input  logic [NUM_NEURONS-1:0]            neuron_outvalid,
    input  logic [NUM_NEURONS*DATA_WIDTH-1:0] neuron_out,
    output logic [DATA_WIDTH-1:0]             out_data,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic                              busy,
    output logic                              layer_done,
    output logic                              err_mismatch,
    output logic                              err_timeout
);

    localparam int IW = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;
    localparam int NW = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1;
    localparam logic [IW-1:0] LAST_IN  = IW'(NUM_INPUTS - 1);
    localparam logic [NW-1:0] LAST_NEU = NW'(NUM_NEURONS - 1);

    if (NUM_INPUTS < 1 || NUM_NEURONS < 1 || DATA_WIDTH < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_param
        $error("layer_sequencer: parameters must all be at least 1");
    end

    typedef enum logic [1:0] {
        S_FILL,
        S_BCAST,
        S_WAIT,
        S_DRAIN
    } state_t;

    state_t                state;
    logic [IW-1:0]         wr_idx;
    logic [IW-1:0]         bc_idx;
    logic [IW-1:0]         bc_next;
    logic [NW-1:0]         rd_idx;
    logic [DATA_WIDTH-1:0] in_buf [NUM_INPUTS];
    logic [DATA_WIDTH-1:0] outreg [NUM_NEURONS];

    logic fill_acc;
    logic drain_hs;
    logic ov_all;
    logic ov_any;

    assign fill_acc = in_valid & in_ready;
    assign drain_hs = out_valid & out_ready;
    assign ov_all   = &neuron_outvalid;
    assign ov_any   = |neuron_outvalid;
    assign bc_next  = bc_idx + 1'b1;

    assign in_ready   = (state == S_FILL);
    assign busy       = (state != S_FILL);
    assign layer_done = drain_hs && (rd_idx == LAST_NEU);
    assign out_data   = out_valid ? outreg[rd_idx] : '0;

`ifdef LAYER_WAIT_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] to_cnt;
    logic          to_expire;
    assign to_expire = (to_cnt == TW'(TIMEOUT_CYCLES - 1));
`else
    assign err_timeout = 1'b0;
`endif

    // Data storage: vector buffer and activation capture registers carry no reset.
    always_ff @(posedge clk) begin
        if (fill_acc) begin
            in_buf[wr_idx] <= in_data;
        end
        if (state == S_WAIT && ov_any) begin
            for (int k = 0; k < NUM_NEURONS; k++) begin
                outreg[k] <= neuron_out[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= S_FILL;
            wr_idx          <= '0;
            bc_idx          <= '0;
            rd_idx          <= '0;
            neuron_in       <= '0;
            neuron_in_valid <= 1'b0;
            out_valid       <= 1'b0;
            err_mismatch    <= 1'b0;
`ifdef LAYER_WAIT_TIMEOUT_EN
            to_cnt          <= '0;
            err_timeout     <= 1'b0;
`endif
        end else begin
            case (state)
                S_FILL: begin
                    if (fill_acc) begin
                        if (wr_idx == LAST_IN) begin
                            // The last word is still being written, so a one-word vector forwards in_data.
                            neuron_in       <= (wr_idx == '0) ? in_data : in_buf[0];
                            neuron_in_valid <= 1'b1;
                            wr_idx          <= '0;
                            bc_idx          <= '0;
                            state           <= S_BCAST;
                        end else begin
                            wr_idx <= wr_idx + 1'b1;
                        end
                    end
                end
                S_BCAST: begin
                    if (bc_idx == LAST_IN) begin
                        neuron_in_valid <= 1'b0;
                        bc_idx          <= '0;
                        state           <= S_WAIT;
`ifdef LAYER_WAIT_TIMEOUT_EN
                        to_cnt          <= '0;
`endif
                    end else begin
                        neuron_in <= in_buf[bc_next];
                        bc_idx    <= bc_next;
                    end
                end
                S_WAIT: begin
                    if (ov_any) begin
                        if (!ov_all) begin
                            err_mismatch <= 1'b1;
                        end
                        out_valid <= 1'b1;
                        rd_idx    <= '0;
                        state     <= S_DRAIN;
                    end
`ifdef LAYER_WAIT_TIMEOUT_EN
                    else if (to_expire) begin
                        err_timeout <= 1'b1;
                        state       <= S_FILL;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
`endif
                end
                S_DRAIN: begin
                    if (drain_hs) begin
                        if (rd_idx == LAST_NEU) begin
                            rd_idx    <= '0;
                            out_valid <= 1'b0;
                            state     <= S_FILL;
                        end else begin
                            rd_idx <= rd_idx + 1'b1;
                        end
                    end
                end
                default: state <= S_FILL;
            endcase
        end
    end

endmodule

// File: tb/tb_layer_sequencer.sv
// Directed bench for layer_sequencer with scoreboard queues for broadcast and drain words.
module tb_layer_sequencer;
    localparam int NI = 4;
    localparam int NN = 3;
    localparam int DW = 16;
    localparam int TO = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic [DW-1:0]    in_data;
    logic             in_valid;
    logic             in_ready;
    logic [DW-1:0]    neuron_in;
    logic             neuron_in_valid;
    logic [NN-1:0]    neuron_outvalid;
    logic [NN*DW-1:0] neuron_out;
    logic [DW-1:0]    out_data;
    logic             out_valid;
    logic             out_ready;
    logic             busy;
    logic             layer_done;
    logic             err_mismatch;
    logic             err_timeout;

    layer_sequencer #(
        .NUM_INPUTS(NI), .NUM_NEURONS(NN), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .rst(rst),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .neuron_in(neuron_in), .neuron_in_valid(neuron_in_valid),
        .neuron_outvalid(neuron_outvalid), .neuron_out(neuron_out),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .busy(busy), .layer_done(layer_done),
        .err_mismatch(err_mismatch), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    logic [DW-1:0] exp_bc[$];
    logic [DW-1:0] exp_out[$];
    int      ld_count = 0;
    int      bc_run = 0;
    bit      prev_niv = 1'b0;
    bit      prev_ld = 1'b0;
    bit      ov_seen = 1'b0;
    bit      hold_pending = 1'b0;
    logic [DW-1:0] hold_data = '0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Output monitor sampling on the falling edge.
    always @(negedge clk) begin
        if (rst) begin
            exp_bc.delete();
            bc_run       = 0;
            prev_niv     = 1'b0;
            prev_ld      = 1'b0;
            hold_pending = 1'b0;
        end else begin
            if (neuron_in_valid) begin
                check("bcast_expected", exp_bc.size() != 0, 1);
                if (exp_bc.size() != 0) check("bcast_word", neuron_in, exp_bc.pop_front());
                check("bcast_in_ready_low", in_ready, 0);
                bc_run++;
            end else if (prev_niv) begin
                check("bcast_len", bc_run, NI);
                bc_run = 0;
            end
            prev_niv = neuron_in_valid;
            if (prev_ld) check("in_ready_after_done", in_ready, 1);
            check("layer_done", layer_done, out_valid && out_ready && (exp_out.size() == 1));
            prev_ld = layer_done;
            if (layer_done) ld_count++;
            if (out_valid) begin
                ov_seen = 1'b1;
                check("drain_in_ready_low", in_ready, 0);
                if (hold_pending) check("drain_hold", out_data, hold_data);
                if (out_ready) begin
                    hold_pending = 1'b0;
                    check("drain_expected", exp_out.size() != 0, 1);
                    if (exp_out.size() != 0) check("drain_word", out_data, exp_out.pop_front());
                end else begin
                    hold_pending = 1'b1;
                    hold_data    = out_data;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic feed(input logic [DW-1:0] base, input int gap);
        for (int i = 0; i < NI; i++) begin
            for (int g = 0; g < gap; g++) begin
                in_valid = 1'b0;
                step();
            end
            in_valid = 1'b1;
            in_data  = base + DW'(i);
            exp_bc.push_back(base + DW'(i));
            begin
                int t = 0;
                while (!in_ready && t < 100) begin
                    step();
                    t++;
                end
            end
            check("feed_ready", in_ready, 1);
            step();
        end
        in_valid = 1'b0;
        check("first_beat_valid", neuron_in_valid, 1);
        check("first_beat_in_ready", in_ready, 0);
    endtask

    task automatic wait_burst_end();
        int t = 0;
        while (neuron_in_valid && t < 50) begin
            step();
            t++;
        end
        check("burst_end", neuron_in_valid, 0);
        check("wait_busy", busy, 1);
    endtask

    task automatic neuron_fire(input logic [NN-1:0] ov, input logic [DW-1:0] a,
                               input logic [DW-1:0] b, input logic [DW-1:0] c, input int lat);
        for (int i = 1; i < lat; i++) step();
        neuron_out      = {c, b, a};
        neuron_outvalid = ov;
        exp_out.push_back(a);
        exp_out.push_back(b);
        exp_out.push_back(c);
        step();
        neuron_outvalid = '0;
        check("out_valid_rise", out_valid, 1);
    endtask

    task automatic drain(input bit bp, output int cycles);
        int i = 0;
        while ((exp_out.size() != 0 || out_valid) && i < 200) begin
            out_ready = bp ? ((i % 4 == 0) || (i % 4 == 3)) : 1'b1;
            step();
            i++;
        end
        cycles    = i;
        out_ready = 1'b1;
        check("drain_complete", out_valid, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        rst = 1'b1; in_valid = 1'b0; in_data = '0;
        neuron_outvalid = '0; neuron_out = '0; out_ready = 1'b1;
        repeat (3) step();
        check("rst_in_ready", in_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_niv", neuron_in_valid, 0);
        check("rst_neuron_in", neuron_in, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_layer_done", layer_done, 0);
        check("rst_err_mismatch", err_mismatch, 0);
        check("rst_err_timeout", err_timeout, 0);
        rst = 1'b0;
        step();

        // Stray outvalid outside WAIT
        neuron_outvalid = 3'b101;
        step();
        neuron_outvalid = '0;
        step();
        check("stray_ov_mismatch", err_mismatch, 0);
        check("stray_ov_busy", busy, 0);
        check("stray_ov_out_valid", out_valid, 0);

        // Nominal
        feed(16'h0001, 0);
        wait_burst_end();
        neuron_fire(3'b111, 16'h00AA, 16'h00BB, 16'h00CC, 5);
        drain(1'b0, cyc);
        check("nominal_drain_cycles", cyc, 3);
        check("nominal_ld_count", ld_count, 1);
        check("nominal_in_ready", in_ready, 1);
        check("nominal_mismatch", err_mismatch, 0);

        // Backpressure
        feed(16'h0010, 0);
        wait_burst_end();
        neuron_fire(3'b111, 16'h1234, 16'h5678, 16'h9ABC, 3);
        drain(1'b1, cyc);
        check("bp_drain_cycles", cyc, 5);
        check("bp_ld_count", ld_count, 2);

        // Upstream gaps
        feed(16'h0020, 2);
        wait_burst_end();
        neuron_fire(3'b111, 16'hFFFF, 16'h8000, 16'h0000, 2);
        drain(1'b0, cyc);
        check("gap_ld_count", ld_count, 3);

        // Mismatch, then a later vector keeps the flag
        feed(16'h0030, 0);
        wait_burst_end();
        neuron_fire(3'b101, 16'h0101, 16'h0202, 16'h0303, 4);
        check("mismatch_set", err_mismatch, 1);
        drain(1'b0, cyc);
        check("mismatch_drain_cycles", cyc, 3);
        check("mismatch_ld_count", ld_count, 4);
        feed(16'h0040, 1);
        wait_burst_end();
        neuron_fire(3'b111, 16'h0A0A, 16'h0B0B, 16'h0C0C, 1);
        drain(1'b1, cyc);
        check("mismatch_sticky", err_mismatch, 1);
        check("mismatch_next_ld", ld_count, 5);

        // Reset on the second broadcast beat
        feed(16'h0050, 0);
        step();
        check("rst_bcast_second_beat", neuron_in_valid, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst_bcast_niv", neuron_in_valid, 0);
        check("rst_bcast_in_ready", in_ready, 1);
        check("rst_bcast_busy", busy, 0);
        check("rst_bcast_out_valid", out_valid, 0);
        check("rst_bcast_mismatch_clr", err_mismatch, 0);
        feed(16'h0060, 0);
        wait_burst_end();
        neuron_fire(3'b111, 16'h1111, 16'h2222, 16'h3333, 5);
        drain(1'b0, cyc);
        check("post_rst_ld_count", ld_count, 6);

`ifdef LAYER_WAIT_TIMEOUT_EN
        ov_seen = 1'b0;
        feed(16'h0070, 0);
        wait_burst_end();
        begin
            int n = 0;
            while (!in_ready && n < 50) begin
                step();
                n++;
            end
            check("timeout_cycles", n, TO);
        end
        check("timeout_flag", err_timeout, 1);
        check("timeout_busy", busy, 0);
        check("timeout_no_out_valid", ov_seen, 0);
        check("timeout_ld_count", ld_count, 6);
`else
        check("no_timeout_flag", err_timeout, 0);
`endif

        step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
